cmd_dispatch: RTL and testbench

//  Parametrised successor to the fixed 5-channel command/config block of the logic analyzer.

---
 rtl/cmd_dispatch_if.sv | 11 +
 rtl/cmd_dispatch.sv | 105 ++++++++++
 tb/tb_cmd_dispatch.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cmd_dispatch_if.sv
// cmd_dispatch_if: host command/response handshake between the UART wrapper and the dispatcher
interface cmd_dispatch_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        resp_sent;
  logic [7:0]  response;
  logic        send_resp;
  logic        clr_cmd_rdy;
  modport master(output cmd, cmd_rdy, resp_sent, input response, send_resp, clr_cmd_rdy);
  modport slave(input cmd, cmd_rdy, resp_sent, output response, send_resp, clr_cmd_rdy);
endinterface

// File: rtl/cmd_dispatch.sv
// cmd_dispatch: decodes host read/write/dump commands over a config register file and RAMqueue channels
module cmd_dispatch #(
  parameter int NUM_CH    = 5,
  parameter int ENTRIES   = 384,
  parameter int LOG2      = 9,
  parameter int REG_DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cmd_dispatch_if.slave          host,
  input  logic                   set_capture_done,
  input  logic [LOG2-1:0]        ram_addr,
  input  logic [NUM_CH*8-1:0]    rdata,
  output logic [LOG2-1:0]        addr_ptr,
  output logic [REG_DEPTH*8-1:0] regs
);
  localparam int AW = REG_DEPTH > 1 ? $clog2(REG_DEPTH) : 1;
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int NW = $clog2(ENTRIES + 1);
  typedef enum logic [2:0] {IDLE, RESP, WAIT, DUMP_RD, DUMP_TX, DUMP_WAIT} state_t;
  state_t          state, state_nxt;
  logic [7:0]      rf [REG_DEPTH];
  logic [NW-1:0]   cnt, cnt_nxt;
  logic [CW-1:0]   ch, ch_nxt;
  logic [LOG2-1:0] ptr_nxt;
  logic [7:0]      resp_nxt;
  logic            send_nxt, clr_nxt, go, wr, reg_ok, ch_ok;
  logic [1:0]      op;
  logic [5:0]      sel;
  assign op     = host.cmd[15:14];
  assign sel    = host.cmd[13:8];
  assign reg_ok = {1'b0, sel} < 7'(REG_DEPTH);
  assign ch_ok  = {1'b0, sel} < 7'(NUM_CH);
  // cmd_rdy is still high during the clr_cmd_rdy cycle; do not re-execute it
  assign go     = state == IDLE && host.cmd_rdy && !host.clr_cmd_rdy;
  assign wr     = go && op == 2'b01 && reg_ok;
  for (genvar k = 0; k < REG_DEPTH; k++) begin : g_regs
    assign regs[8*k +: 8] = rf[k];
  end
  always_comb begin
    state_nxt = state;
    ptr_nxt   = addr_ptr;
    cnt_nxt   = cnt;
    ch_nxt    = ch;
    resp_nxt  = host.response;
    send_nxt  = 1'b0;
    clr_nxt   = 1'b0;
    case (state)
      IDLE: if (go) begin
        ptr_nxt   = ram_addr;
        ch_nxt    = CW'(sel);
        cnt_nxt   = host.cmd[7:0] == 8'h00 ? NW'(ENTRIES) : NW'(host.cmd[7:0]);
        state_nxt = op == 2'b10 && ch_ok ? DUMP_RD : RESP;
        resp_nxt  = op == 2'b00 && reg_ok ? rf[sel[AW-1:0]] : op == 2'b01 && reg_ok ? 8'hA5 : 8'hEE;
      end
      RESP: begin
        send_nxt  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (host.resp_sent) begin
        clr_nxt   = 1'b1;
        state_nxt = IDLE;
      end
      DUMP_RD: state_nxt = DUMP_TX;
      DUMP_TX: begin
        resp_nxt  = rdata[8*ch +: 8];
        send_nxt  = 1'b1;
        state_nxt = DUMP_WAIT;
      end
      DUMP_WAIT: if (host.resp_sent) begin
        cnt_nxt   = cnt - 1'b1;
        clr_nxt   = cnt == NW'(1);
        state_nxt = cnt == NW'(1) ? IDLE : DUMP_RD;
        ptr_nxt   = cnt == NW'(1) ? addr_ptr : addr_ptr == LOG2'(ENTRIES - 1) ? '0 : addr_ptr + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state            <= IDLE;
      addr_ptr         <= '0;
      cnt              <= '0;
      ch               <= '0;
      host.response    <= 8'h00;
      host.send_resp   <= 1'b0;
      host.clr_cmd_rdy <= 1'b0;
    end else begin
      state            <= state_nxt;
      addr_ptr         <= ptr_nxt;
      cnt              <= cnt_nxt;
      ch               <= ch_nxt;
      host.response    <= resp_nxt;
      host.send_resp   <= send_nxt;
      host.clr_cmd_rdy <= clr_nxt;
    end
  // capture-done is applied after the host write so bit 5 survives a coincident reg0 write
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < REG_DEPTH; i++) rf[i] <= i == 0 ? 8'h03 : 8'h00;
    end else begin
      if (wr) rf[sel[AW-1:0]] <= host.cmd[7:0];
      if (set_capture_done) rf[0][5] <= 1'b1;
    end
endmodule

// File: tb/tb_cmd_dispatch.sv
// tb_cmd_dispatch: randomized command stream checked against a queue-based reference model
module tb_cmd_dispatch;
  localparam int NUM_CH = 5, ENTRIES = 384, LOG2 = 9, REG_DEPTH = 32;
  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   set_capture_done;
  logic [LOG2-1:0]        ram_addr;
  logic [NUM_CH*8-1:0]    rdata;
  logic [LOG2-1:0]        addr_ptr;
  logic [REG_DEPTH*8-1:0] regs;
  logic [7:0]             mem [NUM_CH][ENTRIES];
  logic [7:0]             mreg [REG_DEPTH];
  logic [7:0]             exp_q [$];
  logic [7:0]             got_q [$];
  int                     n_cmp = 0, n_err = 0, n_clr = 0, exp_lat = 0;
  cmd_dispatch_if hif();
  cmd_dispatch #(.NUM_CH(NUM_CH), .ENTRIES(ENTRIES), .LOG2(LOG2), .REG_DEPTH(REG_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .host(hif), .set_capture_done(set_capture_done),
    .ram_addr(ram_addr), .rdata(rdata), .addr_ptr(addr_ptr), .regs(regs)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    for (int k = 0; k < NUM_CH; k++) rdata[8*k +: 8] <= mem[k][addr_ptr];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask
  // every response byte the DUT sends must be the next one the model predicted
  always @(negedge clk)
    if (rst_n) begin
      if (hif.send_resp) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_send_resp: got byte %0h expected no byte", hif.response);
        end else chk("response", hif.response, exp_q.pop_front());
        got_q.push_back(hif.response);
      end
      if (hif.clr_cmd_rdy) n_clr++;
    end
  initial begin
    hif.resp_sent = 1'b0;
    forever begin
      @(negedge clk);
      if (hif.send_resp && rst_n) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk); #1 hif.resp_sent = 1'b1;
        @(posedge clk); #1 hif.resp_sent = 1'b0;
      end
    end
  end
  task automatic reset_model();
    for (int k = 0; k < REG_DEPTH; k++) mreg[k] = k == 0 ? 8'h03 : 8'h00;
  endtask
  task automatic model(input logic [15:0] c, input bit cd);
    int op, a, d, n;
    op = int'(c[15:14]);
    a  = int'(c[13:8]);
    d  = int'(c[7:0]);
    if (op == 2 && a < NUM_CH) begin
      n = d == 0 ? ENTRIES : d;
      for (int i = 0; i < n; i++) exp_q.push_back(mem[a][(int'(ram_addr) + i) % ENTRIES]);
      exp_lat = 3;
    end else begin
      exp_lat = 2;
      if (op == 0 && a < REG_DEPTH) exp_q.push_back(mreg[a]);
      else if (op == 1 && a < REG_DEPTH) begin
        exp_q.push_back(8'hA5);
        mreg[a] = c[7:0];
      end else exp_q.push_back(8'hEE);
    end
    if (cd) mreg[0][5] = 1'b1;
  endtask
  task automatic chk_regs();
    for (int k = 0; k < REG_DEPTH; k++) chk($sformatf("reg%0d", k), regs[8*k +: 8], mreg[k]);
  endtask
  task automatic do_cmd(input logic [15:0] c, input bit cd);
    int lat, n;
    model(c, cd);
    got_q.delete();
    n_clr = 0;
    @(posedge clk); #1;
    hif.cmd = c;
    hif.cmd_rdy = 1'b1;
    set_capture_done = cd;
    lat = 0;
    do begin
      @(posedge clk); #1;
      set_capture_done = 1'b0;
      lat++;
    end while (!hif.send_resp && lat < 10);
    chk($sformatf("latency_%h", c), lat, exp_lat);
    n = 0;
    while (!hif.clr_cmd_rdy && n < 8000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("clr_cmd_rdy_seen", hif.clr_cmd_rdy, 1);
    hif.cmd_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk($sformatf("clr_pulses_%h", c), n_clr, 1);
    chk($sformatf("bytes_left_%h", c), exp_q.size(), 0);
    exp_q.delete();
    chk_regs();
  endtask
  task automatic pulse_cd();
    @(posedge clk); #1 set_capture_done = 1'b1;
    mreg[0][5] = 1'b1;
    @(posedge clk); #1 set_capture_done = 1'b0;
  endtask
  initial begin
    int op, a, d, n;
    for (int k = 0; k < NUM_CH; k++)
      for (int i = 0; i < ENTRIES; i++) mem[k][i] = k == 2 ? i[7:0] : 8'($urandom);
    reset_model();
    rst_n = 1'b1;
    hif.cmd = 16'h0;
    hif.cmd_rdy = 1'b0;
    set_capture_done = 1'b0;
    ram_addr = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_response", hif.response, 8'h00);
    chk("rst_send_resp", hif.send_resp, 0);
    chk("rst_clr", hif.clr_cmd_rdy, 0);
    chk("rst_addr_ptr", addr_ptr, 0);
    chk("rst_reg0", regs[7:0], 8'h03);
    do_cmd(16'h0000, 0);
    chk("read_reg0_lit", got_q[0], 8'h03);
    do_cmd(16'h4B0F, 0);
    chk("write_ack_lit", got_q[0], 8'hA5);
    chk("reg11_lit", regs[95:88], 8'h0F);
    do_cmd(16'h0B00, 0);
    chk("read_reg11_lit", got_q[0], 8'h0F);
    ram_addr = 9'd382;
    do_cmd(16'h8204, 0);
    chk("wrap_len_lit", got_q.size(), 4);
    chk("wrap_b0_lit", got_q[0], 8'h7E);
    chk("wrap_b1_lit", got_q[1], 8'h7F);
    chk("wrap_b2_lit", got_q[2], 8'h00);
    chk("wrap_b3_lit", got_q[3], 8'h01);
    ram_addr = 9'd100;
    do_cmd(16'h8100, 0);
    chk("full_dump_len_lit", got_q.size(), 384);
    do_cmd(16'h8700, 0);
    chk("bad_ch_nak_lit", got_q[0], 8'hEE);
    chk("bad_ch_len_lit", got_q.size(), 1);
    do_cmd(16'hC000, 0);
    chk("bad_op_nak_lit", got_q[0], 8'hEE);
    do_cmd(16'h6012, 0);
    chk("bad_addr_nak_lit", got_q[0], 8'hEE);
    pulse_cd();
    chk("capdone_lit", regs[7:0], 8'h23);
    do_cmd(16'h4000, 1);
    chk("write_capdone_lit", regs[7:0], 8'h20);
    for (int t = 0; t < 60; t++) begin
      op = int'($urandom_range(0, 3));
      a  = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 63))
         : op == 2 ? int'($urandom_range(0, NUM_CH - 1)) : int'($urandom_range(0, REG_DEPTH - 1));
      d  = op == 2 ? ($urandom_range(0, 9) == 0 ? 0 : int'($urandom_range(1, 20))) : int'($urandom_range(0, 255));
      ram_addr = LOG2'($urandom_range(0, ENTRIES - 1));
      if ($urandom_range(0, 5) == 0) pulse_cd();
      do_cmd({op[1:0], a[5:0], d[7:0]}, op != 0 && $urandom_range(0, 3) == 0);
    end
    ram_addr = 9'd5;
    model(16'h8100, 0);
    got_q.delete();
    @(posedge clk); #1;
    hif.cmd = 16'h8100;
    hif.cmd_rdy = 1'b1;
    n = 0;
    while (got_q.size() < 3 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("middump_bytes_seen", got_q.size() >= 3, 1);
    n_clr = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("middump_send_resp", hif.send_resp, 0);
    chk("middump_addr_ptr", addr_ptr, 0);
    chk("middump_response", hif.response, 8'h00);
    chk("middump_clr", hif.clr_cmd_rdy, 0);
    hif.cmd_rdy = 1'b0;
    exp_q.delete();
    reset_model();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("middump_no_clr", n_clr, 0);
    chk("middump_addr_ptr_idle", addr_ptr, 0);
    do_cmd(16'h0000, 0);
    chk("post_reset_read_lit", got_q[0], 8'h03);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
